// File: rtl/addsub_share_arb.sv
// addsub_share_arb: round-robin scheduler that time-shares one 16-bit add/sub
// datapath between NREQ requesters and returns results over a single
// valid/ready response port.
// Optional feature macro: ADDSUB_ARB_WIDE_EN. When it is defined, 32-bit
// operations run as two carry-chained 16-bit passes (LO then HI).
module addsub_share_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*32-1:0] req_a,
    input  logic [NREQ*32-1:0] req_b,
    input  logic [NREQ-1:0]    req_sub,
    input  logic [NREQ-1:0]    req_wide,
    output logic [15:0]        dp_a,
    output logic [15:0]        dp_b,
    output logic               dp_sub,
    output logic               dp_cin,
    input  logic [15:0]        dp_sum,
    input  logic               dp_cout,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [31:0]        rsp_sum,
    output logic               rsp_cout
);

    typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

    state_t         state;
    logic [IDW-1:0] ptr;        // last granted requester; also the in-flight ID
    logic           grant_vld;
    logic [IDW-1:0] grant_id;
    logic [31:0]    sel_a;
    logic [31:0]    sel_b;
    logic           sel_sub;
    logic           go_hi;

`ifdef ADDSUB_ARB_WIDE_EN
    logic           wide;
    logic           sel_wide;
    logic [15:0]    a_hi;
    logic [15:0]    b_hi;
    logic [15:0]    sum_lo;

    assign go_hi = wide;
`else
    // Upper operand halves and the wide flags have no consumer in this build.
    logic unused_wide;
    assign unused_wide = ^{req_wide, sel_a[31:16], sel_b[31:16]};
    assign go_hi       = 1'b0;
`endif

    // Round-robin search starting at ptr+1; descending loop so the nearest wins.
    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_id  = '0;
        sel_a     = '0;
        sel_b     = '0;
        sel_sub   = 1'b0;
`ifdef ADDSUB_ARB_WIDE_EN
        sel_wide  = 1'b0;
`endif
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(ptr) + k) % NREQ;
            if (req_valid[idx]) begin
                grant_vld = 1'b1;
                grant_id  = IDW'(idx);
                sel_a     = req_a[idx*32 +: 32];
                sel_b     = req_b[idx*32 +: 32];
                sel_sub   = req_sub[idx];
`ifdef ADDSUB_ARB_WIDE_EN
                sel_wide  = req_wide[idx];
`endif
            end
        end
    end

    // One-hot accept, only while idle and never during reset.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && grant_vld && !rst)
            req_ready[grant_id] = 1'b1;
    end

    // Control FSM; datapath drive and response are registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= IDW'(NREQ - 1);
            dp_a      <= '0;
            dp_b      <= '0;
            dp_sub    <= 1'b0;
            dp_cin    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
`ifdef ADDSUB_ARB_WIDE_EN
            wide      <= 1'b0;
            a_hi      <= '0;
            b_hi      <= '0;
            sum_lo    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        ptr    <= grant_id;
                        dp_a   <= sel_a[15:0];
                        dp_b   <= sel_b[15:0];
                        dp_sub <= sel_sub;
                        dp_cin <= sel_sub;   // +1 of two's complement for subtract
`ifdef ADDSUB_ARB_WIDE_EN
                        wide   <= sel_wide;
                        a_hi   <= sel_a[31:16];
                        b_hi   <= sel_b[31:16];
`endif
                        state  <= LO;
                    end
                end
                LO: begin
                    if (go_hi) begin
`ifdef ADDSUB_ARB_WIDE_EN
                        sum_lo <= dp_sum;
                        dp_a   <= a_hi;
                        dp_b   <= b_hi;
                        dp_cin <= dp_cout;   // chain low-half carry into high half
                        state  <= HI;
`endif
                    end else begin
                        dp_a      <= '0;
                        dp_b      <= '0;
                        dp_sub    <= 1'b0;
                        dp_cin    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_id    <= ptr;
                        rsp_sum   <= {16'h0000, dp_sum};
                        rsp_cout  <= dp_cout;
                        state     <= RESP;
                    end
                end
`ifdef ADDSUB_ARB_WIDE_EN
                HI: begin
                    dp_a      <= '0;
                    dp_b      <= '0;
                    dp_sub    <= 1'b0;
                    dp_cin    <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_id    <= ptr;
                    rsp_sum   <= {dp_sum, sum_lo};
                    rsp_cout  <= dp_cout;
                    state     <= RESP;
                end
`endif
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_share_arb.sv
// Directed testbench for addsub_share_arb with a behavioural 16-bit adder
// attached to the shared datapath port.
module tb_addsub_share_arb;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*32-1:0] req_a;
    logic [NREQ*32-1:0] req_b;
    logic [NREQ-1:0]    req_sub;
    logic [NREQ-1:0]    req_wide;
    logic [15:0]        dp_a;
    logic [15:0]        dp_b;
    logic               dp_sub;
    logic               dp_cin;
    logic [15:0]        dp_sum;
    logic               dp_cout;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [31:0]        rsp_sum;
    logic               rsp_cout;

    int tests  = 0;
    int failed = 0;

    addsub_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sub(req_sub), .req_wide(req_wide),
        .dp_a(dp_a), .dp_b(dp_b), .dp_sub(dp_sub), .dp_cin(dp_cin),
        .dp_sum(dp_sum), .dp_cout(dp_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout)
    );

    always #5 clk = ~clk;

    // External shared adder: a + (sub ? ~b : b) + cin
    logic [16:0] dp_full;
    assign dp_full = {1'b0, dp_a} + {1'b0, (dp_sub ? ~dp_b : dp_b)} + {16'h0, dp_cin};
    assign dp_sum  = dp_full[15:0];
    assign dp_cout = dp_full[16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic sub, input logic wide);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
        req_sub[i]        = sub;
        req_wide[i]       = wide;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Present one request, return req_ready seen in the accept cycle and the
    // cycle count from accept to rsp_valid (8 means it never came).
    task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic wide,
                         output logic [NREQ-1:0] rdy, output int lat);
        set_req(i, a, b, sub, wide);
        req_valid[i] = 1'b1;
        #1;
        rdy = req_ready;
        tick();
        req_valid[i] = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 8) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        req_valid = '1;
        do_reset();
        req_valid = '0;
        #1;
        tests++; if (req_ready !== 4'b0000) begin failed++; $display("FAIL reset_req_ready got %h want 0", req_ready); end
        tests++; if (rsp_valid !== 1'b0) begin failed++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        tests++; if ({rsp_id, rsp_sum, rsp_cout} !== '0) begin failed++; $display("FAIL reset_rsp got id=%0d sum=%h cout=%b want 0", rsp_id, rsp_sum, rsp_cout); end
        tests++; if ({dp_a, dp_b, dp_sub, dp_cin} !== '0) begin failed++; $display("FAIL reset_dp got a=%h b=%h sub=%b cin=%b want 0", dp_a, dp_b, dp_sub, dp_cin); end
    endtask

    task automatic test_narrow_add();
        logic [NREQ-1:0] rdy;
        int lat;
        issue(0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, rdy, lat);
        tests++; if (rdy !== 4'b0001) begin failed++; $display("FAIL add_grant got %b want 0001", rdy); end
        tests++; if (lat !== 2) begin failed++; $display("FAIL add_latency got %0d want 2", lat); end
        tests++; if (rsp_id !== 2'd0) begin failed++; $display("FAIL add_id got %0d want 0", rsp_id); end
        tests++; if (rsp_sum !== 32'h0000_0100 || rsp_cout !== 1'b0) begin failed++; $display("FAIL add_result got %h/%b want 00000100/0", rsp_sum, rsp_cout); end
        tests++; if ({dp_a, dp_b, dp_sub, dp_cin} !== '0) begin failed++; $display("FAIL resp_dp_zero got a=%h b=%h", dp_a, dp_b); end
        tick();
    endtask

    task automatic test_narrow_sub();
        logic [NREQ-1:0] rdy;
        int lat;
        issue(2, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, rdy, lat);
        tests++; if (rdy !== 4'b0100) begin failed++; $display("FAIL sub1_grant got %b want 0100", rdy); end
        tests++; if (lat !== 2 || rsp_id !== 2'd2) begin failed++; $display("FAIL sub1_lat_id got lat=%0d id=%0d want 2/2", lat, rsp_id); end
        tests++; if (rsp_sum !== 32'h0000_FFFE || rsp_cout !== 1'b0) begin failed++; $display("FAIL sub1_result got %h/%b want 0000fffe/0", rsp_sum, rsp_cout); end
        tick();
        issue(2, 32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0, rdy, lat);
        tests++; if (rsp_sum !== 32'h0000_0002 || rsp_cout !== 1'b1) begin failed++; $display("FAIL sub2_result got %h/%b want 00000002/1", rsp_sum, rsp_cout); end
        tick();
    endtask

    task automatic test_wide();
        set_req(1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        req_valid[1] = 1'b1;
        tick();
        req_valid[1] = 1'b0;
        tests++; if (dp_a !== 16'hFFFF || dp_b !== 16'h0001 || dp_cin !== 1'b0) begin failed++; $display("FAIL wide_lo_dp got a=%h b=%h cin=%b want ffff/0001/0", dp_a, dp_b, dp_cin); end
        tick();
`ifdef ADDSUB_ARB_WIDE_EN
        tests++; if (dp_a !== 16'h0000 || dp_b !== 16'h0000 || dp_cin !== 1'b1 || rsp_valid !== 1'b0) begin failed++; $display("FAIL wide_hi_dp got a=%h b=%h cin=%b v=%b want 0/0/1/0", dp_a, dp_b, dp_cin, rsp_valid); end
        tick();
        tests++; if (rsp_valid !== 1'b1 || rsp_sum !== 32'h0001_0000 || rsp_cout !== 1'b0) begin failed++; $display("FAIL wide_result got v=%b %h/%b want 1 00010000/0", rsp_valid, rsp_sum, rsp_cout); end
`else
        tests++; if (rsp_valid !== 1'b1 || rsp_sum !== 32'h0000_0000 || rsp_cout !== 1'b1) begin failed++; $display("FAIL wide_off_result got v=%b %h/%b want 1 00000000/1", rsp_valid, rsp_sum, rsp_cout); end
`endif
        tests++; if (rsp_id !== 2'd1) begin failed++; $display("FAIL wide_id got %0d want 1", rsp_id); end
        tick();
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 32'(i), 32'h1, 1'b0, 1'b0);
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            #1;
            tests++; if (req_ready !== 4'(1 << (k % 4))) begin failed++; $display("FAIL rr_grant%0d got %b want %b", k, req_ready, 4'(1 << (k % 4))); end
            tick();
            tests++; if (req_ready !== 4'b0000) begin failed++; $display("FAIL rr_busy%0d got %b want 0000", k, req_ready); end
            tick();
            tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(k % 4) || rsp_sum !== 32'(k % 4 + 1)) begin failed++; $display("FAIL rr_rsp%0d got v=%b id=%0d sum=%h want 1/%0d/%0d", k, rsp_valid, rsp_id, rsp_sum, k % 4, k % 4 + 1); end
            tick();
        end
        req_valid = '0;
    endtask

    task automatic test_back_pressure();
        logic [NREQ-1:0] rdy;
        int lat;
        do_reset();
        rsp_ready = 1'b0;
        issue(1, 32'h0000_1234, 32'h0000_0001, 1'b0, 1'b0, rdy, lat);
        req_valid[3] = 1'b1;
        set_req(3, 32'h0, 32'h0, 1'b0, 1'b0);
        tests++; if (lat !== 2) begin failed++; $display("FAIL bp_latency got %0d want 2", lat); end
        for (int c = 0; c < 5; c++) begin
            tick();
            tests++; if (rsp_valid !== 1'b1 || rsp_sum !== 32'h0000_1235 || rsp_id !== 2'd1 || req_ready !== 4'b0000) begin failed++; $display("FAIL bp_hold%0d got v=%b sum=%h id=%0d rdy=%b want 1/00001235/1/0000", c, rsp_valid, rsp_sum, rsp_id, req_ready); end
        end
        rsp_ready = 1'b1;
        tick();
        tests++; if (rsp_valid !== 1'b0 || req_ready !== 4'b1000) begin failed++; $display("FAIL bp_release got v=%b rdy=%b want 0/1000", rsp_valid, req_ready); end
        tick();
        req_valid = '0;
        tick();
        tick();
    endtask

    task automatic test_abort();
        int seen;
        do_reset();
        // Reset held alongside valid requests: nothing accepted.
        rst = 1'b1;
        req_valid = 4'b1111;
        #1;
        tests++; if (req_ready !== 4'b0000) begin failed++; $display("FAIL rst_with_valid got %b want 0000", req_ready); end
        tick();
        req_valid = '0;
        rst = 1'b0;
        tests++; if (dp_a !== 16'h0 || rsp_valid !== 1'b0) begin failed++; $display("FAIL rst_no_accept got dp_a=%h v=%b want 0/0", dp_a, rsp_valid); end
        // Accept req2 and abort it in LO.
        set_req(2, 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);
        req_valid[2] = 1'b1;
        tick();
        req_valid[2] = 1'b0;
        tests++; if (dp_a !== 16'h0010) begin failed++; $display("FAIL abort_lo_dp got %h want 0010", dp_a); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++; if (rsp_valid !== 1'b0 || dp_a !== 16'h0 || dp_b !== 16'h0) begin failed++; $display("FAIL abort_state got v=%b a=%h b=%h want 0/0/0", rsp_valid, dp_a, dp_b); end
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (rsp_valid) seen++;
        end
        tests++; if (seen !== 0) begin failed++; $display("FAIL abort_no_rsp got %0d responses want 0", seen); end
        req_valid = 4'b1110;
        req_valid[0] = 1'b1;
        #1;
        tests++; if (req_ready !== 4'b0001) begin failed++; $display("FAIL abort_next_grant got %b want 0001", req_ready); end
        req_valid = '0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_sub   = '0;
        req_wide  = '0;
        rsp_ready = 1'b1;
        test_reset();
        test_narrow_add();
        test_narrow_sub();
        test_wide();
        test_round_robin();
        test_back_pressure();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/addsub_share_arb.md
# addsub_share_arb

Round-robin scheduler that shares one 16-bit carry-select add/sub datapath between `NREQ` requesters in the reconfigurable MAC. It accepts operations over per-requester valid/ready handshakes and drives the shared adder's operand, mode and carry-in lines. It returns each result with the requester ID over a single valid/ready response port. With the wide option compiled in, it also sequences 32-bit operations as two carry-chained 16-bit passes.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `IDW`, $clog2(NREQ): requester ID width.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester accept; at most one bit high in any cycle.
- `req_a`, `req_b`  in  NREQ*32  operands, packed; requester i uses bits [32i+31:32i].
- `req_sub`  in  NREQ  1 = A−B, 0 = A+B.
- `req_wide`  in  NREQ  1 = 32-bit operation, 0 = 16-bit (low halves only).
- `dp_a`, `dp_b`  out  16  shared datapath operands.
- `dp_sub`  out  1  datapath mode; the datapath computes dp_a + (dp_sub ? ~dp_b : dp_b) + dp_cin.
- `dp_cin`  out  1  datapath carry-in.
- `dp_sum`  in  16  datapath sum; combinational, same cycle.
- `dp_cout`  in  1  datapath carry-out.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  consumer accept.
- `rsp_id`  out  IDW  requester index of the result.
- `rsp_sum`  out  32  result; bits [31:16] are 0 for 16-bit operations.
- `rsp_cout`  out  1  final carry; for subtraction, 1 means no borrow.

## Operation
- The FSM has four states: IDLE, LO, HI and RESP.
- **IDLE**
  - The arbiter scans from `ptr+1` upward with wrap-around and grants the first i with `req_valid[i]`.
  - `req_ready[g]` is driven combinationally for the granted i only.
  - On accept, the block latches a, b, sub, wide and id, sets `ptr`←g and moves to LO.
  - If no request is valid, the FSM stays in IDLE and `ptr` is unchanged.
- **LO**
  - Drives `dp_a`=a[15:0], `dp_b`=b[15:0], `dp_sub`=sub, `dp_cin`=sub.
  - Latches sum[15:0]←`dp_sum` and carry←`dp_cout`.
  - Next state is HI if wide, otherwise RESP.
- **HI**
  - Drives `dp_a`=a[31:16], `dp_b`=b[31:16], `dp_sub`=sub, `dp_cin`=latched carry.
  - Latches sum[31:16] and carry, then moves to RESP.
- **RESP**
  - `rsp_valid`=1. `rsp_id`, `rsp_sum` and `rsp_cout` are held stable until `rsp_ready`.
  - On `rsp_valid & rsp_ready`, the FSM returns to IDLE.
  - No new request is accepted in the RESP cycle.
- The `dp_*` outputs are 0 in IDLE and RESP.
- Arithmetic is modulo 2^16 (narrow) or 2^32 (wide). There is no saturation and no overflow flag.
- A request withdrawn before it is granted is simply not served. `req_valid` is not required to be sticky.

## Timing
- Reset values:
  - state IDLE, `ptr`=NREQ−1 (requester 0 wins first).
  - `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_sum`=0, `rsp_cout`=0.
  - all `dp_*` outputs = 0.
- Latency from accept edge (cycle T) to `rsp_valid`:
  - narrow: high in cycle T+2.
  - wide: high in cycle T+3.
- The earliest next accept is the cycle after the response handshake. Minimum issue interval is 3 cycles (narrow) or 4 cycles (wide).
- `rst` in any state aborts the in-flight operation with no response. The reset values apply from the next cycle, and `ptr` is reset.
- `rst` together with `req_valid`: no accept occurs.
- Back-pressure: `rsp_ready`=0 holds RESP indefinitely, and all `req_ready` stay 0.

## Configuration
- `ADDSUB_ARB_WIDE_EN` defined:
  - `req_wide` is honoured and the HI state exists.
  - Wide results use the full 32-bit `rsp_sum`.
- `ADDSUB_ARB_WIDE_EN` undefined:
  - `req_wide` is ignored and the HI state is not synthesised.
  - Every operation is narrow: LO→RESP, latency T+2, `rsp_sum[31:16]`=0.

## Test plan
- Narrow add, req0: a=0x00FF, b=0x0001, sub=0 → `rsp_valid` at T+2, `rsp_id`=0, `rsp_sum`=0x0000_0100, `rsp_cout`=0.
- Narrow sub, req2: a=0x0005, b=0x0007 → `rsp_sum`=0x0000_FFFE, `rsp_cout`=0 (borrow). Second op a=0x0007, b=0x0005 → `rsp_sum`=0x0002, `rsp_cout`=1.
- Wide add, a=0x0000_FFFF, b=0x0000_0001:
  - macro on → HI pass with `dp_cin`=1, `rsp_sum`=0x0001_0000, `rsp_cout`=0 at T+3.
  - macro off → `rsp_sum`=0x0000_0000, `rsp_cout`=1 at T+2.
- All four `req_valid` held high, `rsp_ready`=1 → grants in order 0,1,2,3,0,1; exactly one `req_ready` bit high per accept.
- `rsp_ready`=0 for 5 cycles in RESP → `rsp_sum`/`rsp_id` stable, all `req_ready`=0. On release, handshake completes and the next grant follows in IDLE.
- `rst` pulsed during LO (or HI) → next cycle IDLE, `rsp_valid`=0, no response for the aborted op, next grant goes to requester 0.
